// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and instruction constants for the fetch controller
package fetch_pkg;
  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RESP = 3'd2,
    DRAIN     = 3'd3,
    HOLD      = 3'd4
  } fetch_state_t;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: I-side request/response handshake between fetch and the L1 cache
interface fetch_controller_if #(parameter int PC_SIZE = 32);
  logic               l1_req;
  logic [PC_SIZE-1:0] l1_addr;
  logic               l1_ready;
  logic               l1_rvalid;
  logic [31:0]        l1_rdata;
  modport master (output l1_req, l1_addr, input l1_ready, l1_rvalid, l1_rdata);
  modport slave  (input l1_req, l1_addr, output l1_ready, l1_rvalid, l1_rdata);
endinterface

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: 32-bit wrapping event counter with increment enable
module fetch_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (en) count <= count + 32'd1;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding I-fetch sequencer with redirect and squash.
// Define FETCH_PERF_EN to add fetch_count/squash_count performance counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int PC_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [PC_SIZE-1:0]     redirect_target,
  input  logic                   stall,
  fetch_controller_if.master     l1,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_SIZE-1:0]     instr_pc,
  output logic                   fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            squash_count
`endif
);
  fetch_state_t state, state_nx;
  logic [PC_SIZE-1:0] pc, pc_nx;
  logic redir, accept, rvalid, capture, consume, squash;
  assign redir   = redirect_valid && state != BOOT;
  assign accept  = state == ISSUE && l1.l1_ready;
  assign rvalid  = l1.l1_rvalid;
  assign capture = state == WAIT_RESP && rvalid && !redir;
  assign consume = state == HOLD && !stall && !redir;
  // a response is squashed if it belongs to a pre-redirect fetch; a held instr is squashed by any redirect
  assign squash  = (rvalid && (state == DRAIN || (state == WAIT_RESP && redir))) || (state == HOLD && redir);
  assign l1.l1_req   = state == ISSUE;
  assign l1.l1_addr  = pc;
  assign instr_valid = state == HOLD;
  assign fetch_busy  = ~instr_valid;
  assign pc_nx = redir ? (redirect_target & ~PC_SIZE'(3)) : consume ? pc + PC_SIZE'(4) : pc;
  always_comb begin
    state_nx = state;
    case (state)
      BOOT:      state_nx = ISSUE;
      ISSUE:     state_nx = accept ? (redir ? DRAIN : WAIT_RESP) : ISSUE;
      WAIT_RESP: state_nx = rvalid ? (redir ? ISSUE : HOLD) : (redir ? DRAIN : WAIT_RESP);
      DRAIN:     state_nx = rvalid ? ISSUE : DRAIN;
      HOLD:      state_nx = (redir || !stall) ? ISSUE : HOLD;
      default:   state_nx = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (capture) begin
        instr    <= l1.l1_rdata;
        instr_pc <= pc;
      end
    end
`ifdef FETCH_PERF_EN
  fetch_perf_counter u_fetch_cnt  (.clk(clk), .reset(reset), .en(consume), .count(fetch_count));
  fetch_perf_counter u_squash_cnt (.clk(clk), .reset(reset), .en(squash),  .count(squash_count));
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: bench acting as L1 memory plus a transaction-level model of fetch ordering
module tb_fetch_controller;
  import fetch_pkg::*;
  logic        clk = 0, reset = 0, redirect_valid = 0, stall = 0;
  logic [31:0] redirect_target = 0;
  logic        instr_valid, fetch_busy;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, squash_count;
`endif
  fetch_controller_if #(.PC_SIZE(32)) l1 ();
  fetch_controller #(.PC_SIZE(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall(stall), .l1(l1), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .squash_count(squash_count)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic ready_block = 0;
  int   resp_delay = 0;
  logic        boot = 1, out_valid = 0, out_stale = 0, hold_valid = 0;
  logic [31:0] exp_pc = 0, out_tag = 0, hold_pc = 0;
  int          out_delay = 0, n_fetch = 0, n_squash = 0;
  int          acc_cyc[$];
  logic [31:0] acc_addr[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one fetch in flight, none while an instruction is held; a redirect marks in-flight work stale.
  always @(negedge clk) begin
    logic rv, rd, acc, req_exp;
    cyc++;
    if (!reset) begin
      boot = 1; exp_pc = 0; out_valid = 0; out_stale = 0; out_tag = 0; out_delay = 0;
      hold_valid = 0; hold_pc = 0; n_fetch = 0; n_squash = 0;
      l1.l1_ready = 0; l1.l1_rvalid = 0; l1.l1_rdata = 0;
    end else begin
      req_exp = !boot && !out_valid && !hold_valid;
      check("l1_req", {31'b0, l1.l1_req}, {31'b0, req_exp});
      if (req_exp) check("l1_addr", l1.l1_addr, exp_pc);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, hold_valid});
      check("fetch_busy", {31'b0, fetch_busy}, {31'b0, !hold_valid});
      if (hold_valid) begin
        check("instr_pc", instr_pc, hold_pc);
        check("instr", instr, mem(hold_pc));
      end
`ifdef FETCH_PERF_EN
      check("fetch_count", fetch_count, n_fetch);
      check("squash_count", squash_count, n_squash);
`endif
      rv = out_valid && out_delay == 0;
      l1.l1_ready  = !ready_block;
      l1.l1_rvalid = rv;
      l1.l1_rdata  = rv ? mem(out_tag) : 32'hDEAD_BEEF;
      rd  = redirect_valid && !boot;
      acc = req_exp && !ready_block;
      if (boot) boot = 0;
      else begin
        if (hold_valid && (rd || !stall)) begin
          if (rd) n_squash++;
          else begin n_fetch++; exp_pc = exp_pc + 4; end
          hold_valid = 0;
        end
        if (rv) begin
          if (out_stale || rd) n_squash++;
          else begin hold_valid = 1; hold_pc = out_tag; end
          out_valid = 0;
        end else if (out_valid) begin
          out_stale = out_stale || rd;
          if (out_delay > 0) out_delay--;
        end
        if (acc) begin
          out_valid = 1; out_tag = exp_pc; out_stale = rd; out_delay = resp_delay;
          acc_cyc.push_back(cyc); acc_addr.push_back(exp_pc);
        end
        if (rd) exp_pc = redirect_target & ~32'h3;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!instr_valid && n < 50) begin step(); n++; end
    check("wait_hold", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_acc(input int cnt);
    int n = 0;
    while (acc_addr.size() < cnt && n < 100) begin step(); n++; end
    check("wait_acc", acc_addr.size(), cnt);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_req"}, {31'b0, l1.l1_req}, 32'd0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, fetch_busy}, 32'd1);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    int base;
    repeat (2) step();
    reset_vals("rst");
    reset = 1;
    // back-to-back fetches, zero-wait L1
    wait_acc(3);
    check("acc0", acc_addr[0], 32'h0);
    check("acc1", acc_addr[1], 32'h4);
    check("acc2", acc_addr[2], 32'h8);
    check("period01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("period12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    // L1 not ready for 4 cycles
    wait_hold();
    check("hold8_pc", instr_pc, 32'h8);
    ready_block = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("held_req", {31'b0, l1.l1_req}, 32'd1);
      check("held_addr", l1.l1_addr, 32'hC);
      step();
    end
    ready_block = 0;
    step();
    check("acc_c", acc_addr[3], 32'hC);
    // decode stall while holding
    wait_hold();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_pc", instr_pc, 32'hC);
      check("stall_instr", instr, 32'h1357_9BD3);
      step();
    end
    stall = 0;
    step();
    check("after_stall_addr", l1.l1_addr, 32'h10);
    // redirect while waiting for a response -> squash
    resp_delay = 2;
    step();
    redirect_valid = 1; redirect_target = 32'h103;
    step();
    redirect_valid = 0; resp_delay = 0;
    for (int n = 0; n < 20 && !l1.l1_req; n++) begin
      check("drain_valid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    check("redir_addr", l1.l1_addr, 32'h100);
`ifdef FETCH_PERF_EN
    check("squash1", squash_count, 32'd1);
`endif
    // redirect coincident with response
    step();
    redirect_valid = 1; redirect_target = 32'h200;
    step();
    redirect_valid = 0;
    check("coin_req", {31'b0, l1.l1_req}, 32'd1);
    check("coin_addr", l1.l1_addr, 32'h200);
    check("coin_valid", {31'b0, instr_valid}, 32'd0);
    wait_hold();
    check("coin_pc", instr_pc, 32'h200);
    check("coin_instr", instr, 32'h1357_99DF);
    // redirect from HOLD to top of address space, then wrap
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    check("top_addr", l1.l1_addr, 32'hFFFF_FFFC);
    wait_hold();
    check("top_pc", instr_pc, 32'hFFFF_FFFC);
    resp_delay = 3;
    step();
    check("wrap_req", {31'b0, l1.l1_req}, 32'd1);
    check("wrap_addr", l1.l1_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check("squash3", squash_count, 32'd3);
`endif
    // asynchronous reset while a request is outstanding
    step();
    #2 reset = 0;
    #1 reset_vals("async");
    resp_delay = 0;
    step(); step();
    reset = 1;
    base = acc_addr.size();
    wait_acc(base + 2);
    check("post_acc0", acc_addr[base], 32'h0);
    check("post_acc1", acc_addr[base + 1], 32'h4);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
